// File: rtl/router_port_sync.sv
`default_nettype none
// ============================================================================
// Module   : router_port_sync
// Purpose  : 1x3 router destination control: address latch, FIFO write steering,
//            per-port valid outputs and stall watchdog with soft_reset pulses.
// Revision : 1.0
// ============================================================================
module router_port_sync #(
  parameter int TIMEOUT = 30,
  parameter int CNT_W   = 5
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       detect_add,
  input  logic [1:0] data_in,
  input  logic       write_enb_reg,
  input  logic       empty_0,
  input  logic       empty_1,
  input  logic       empty_2,
  input  logic       full_0,
  input  logic       full_1,
  input  logic       full_2,
  input  logic       read_enb_0,
  input  logic       read_enb_1,
  input  logic       read_enb_2,
  output logic [2:0] write_enb,
  output logic       fifo_full,
  output logic       vld_out_0,
  output logic       vld_out_1,
  output logic       vld_out_2,
  output logic       soft_reset_0,
  output logic       soft_reset_1,
  output logic       soft_reset_2
);

  localparam logic [1:0]       ADDR_NONE = 2'b11;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT - 1);

  logic [1:0] addr_q;
  logic [2:0] vld_vec;
  logic [2:0] rd_vec;
  logic [2:0] soft_reset_vec;

  always_ff @(posedge clock) begin
    if (reset) begin
      addr_q <= ADDR_NONE;
    end else if (detect_add) begin
      addr_q <= data_in;
    end
  end

  // Steering uses the registered address, so a header-cycle write goes to the old port.
  always_comb begin
    write_enb = 3'b000;
    fifo_full = 1'b0;
    case (addr_q)
      2'd0: begin
        write_enb = {2'b00, write_enb_reg};
        fifo_full = full_0;
      end
      2'd1: begin
        write_enb = {1'b0, write_enb_reg, 1'b0};
        fifo_full = full_1;
      end
      2'd2: begin
        write_enb = {write_enb_reg, 2'b00};
        fifo_full = full_2;
      end
      default: begin
        write_enb = 3'b000;
        fifo_full = 1'b0;
      end
    endcase
  end

  assign vld_vec = {~empty_2, ~empty_1, ~empty_0};
  assign rd_vec  = {read_enb_2, read_enb_1, read_enb_0};

  assign vld_out_0 = vld_vec[0];
  assign vld_out_1 = vld_vec[1];
  assign vld_out_2 = vld_vec[2];

  generate
    for (genvar i = 0; i < 3; i++) begin : g_port
      logic [CNT_W-1:0] cnt;
      logic             pulse;
      logic             stall;

      assign stall = vld_vec[i] & ~rd_vec[i];

      // Counter restarts at the pulse so a persistent stall pulses every TIMEOUT cycles.
      always_ff @(posedge clock) begin
        if (reset) begin
          cnt   <= '0;
          pulse <= 1'b0;
        end else if (!stall) begin
          cnt   <= '0;
          pulse <= 1'b0;
        end else if (cnt == CNT_LAST) begin
          cnt   <= '0;
          pulse <= 1'b1;
        end else begin
          cnt   <= cnt + CNT_W'(1);
          pulse <= 1'b0;
        end
      end

      assign soft_reset_vec[i] = pulse;
    end
  endgenerate

  assign soft_reset_0 = soft_reset_vec[0];
  assign soft_reset_1 = soft_reset_vec[1];
  assign soft_reset_2 = soft_reset_vec[2];

endmodule
`default_nettype wire

// File: tb/tb_router_port_sync.sv
`default_nettype none
// ============================================================================
// Module   : tb_router_port_sync
// Purpose  : Directed plus randomized bench for router_port_sync, checked against
//            a stall-run-length reference model every cycle.
// Revision : 1.0
// ============================================================================
module tb_router_port_sync;

  localparam int TIMEOUT = 30;

  logic       clock = 1'b0;
  logic       reset;
  logic       detect_add;
  logic [1:0] data_in;
  logic       write_enb_reg;
  logic [2:0] empty;
  logic [2:0] full;
  logic [2:0] read_enb;
  logic [2:0] write_enb;
  logic       fifo_full;
  logic       vld_out_0, vld_out_1, vld_out_2;
  logic       soft_reset_0, soft_reset_1, soft_reset_2;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state: latched port and consecutive stalled edges per port.
  int m_addr = 3;
  int m_run[3];
  logic [2:0] m_sr = 3'b000;

  router_port_sync #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
    .clock(clock), .reset(reset), .detect_add(detect_add), .data_in(data_in),
    .write_enb_reg(write_enb_reg),
    .empty_0(empty[0]), .empty_1(empty[1]), .empty_2(empty[2]),
    .full_0(full[0]), .full_1(full[1]), .full_2(full[2]),
    .read_enb_0(read_enb[0]), .read_enb_1(read_enb[1]), .read_enb_2(read_enb[2]),
    .write_enb(write_enb), .fifo_full(fifo_full),
    .vld_out_0(vld_out_0), .vld_out_1(vld_out_1), .vld_out_2(vld_out_2),
    .soft_reset_0(soft_reset_0), .soft_reset_1(soft_reset_1), .soft_reset_2(soft_reset_2)
  );

  always #5 clock = ~clock;

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Model update on each rising edge, comparison midway through the low phase.
  initial begin
    m_run = '{0, 0, 0};
    forever begin
      @(posedge clock);
      if (reset) begin
        m_addr = 3;
        m_run  = '{0, 0, 0};
        m_sr   = 3'b000;
      end else begin
        if (detect_add) m_addr = int'(data_in);
        for (int i = 0; i < 3; i++) begin
          if (!empty[i] && !read_enb[i]) begin
            m_run[i]++;
            m_sr[i] = (m_run[i] % TIMEOUT) == 0;
          end else begin
            m_run[i] = 0;
            m_sr[i]  = 1'b0;
          end
        end
      end
      @(negedge clock);
      #2;
      check("write_enb", {5'd0, write_enb},
            (m_addr != 3 && write_enb_reg) ? 8'(1 << m_addr) : 8'd0);
      check("fifo_full", {7'd0, fifo_full}, (m_addr != 3) ? {7'd0, full[m_addr]} : 8'd0);
      check("vld_out", {5'd0, vld_out_2, vld_out_1, vld_out_0}, {5'd0, ~empty});
      check("soft_reset", {5'd0, soft_reset_2, soft_reset_1, soft_reset_0}, {5'd0, m_sr});
    end
  end

  task automatic idle();
    reset = 1'b0; detect_add = 1'b0; data_in = 2'd0; write_enb_reg = 1'b0;
    empty = 3'b111; full = 3'b000; read_enb = 3'b000;
  endtask

  task automatic next_cycle();
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
  endtask

  initial begin
    idle();
    reset = 1'b1;
    next_cycle(); next_cycle();
    reset = 1'b0;
    #3;
    check("pin_reset_we", {5'd0, write_enb}, 8'd0);
    check("pin_reset_sr", {5'd0, soft_reset_2, soft_reset_1, soft_reset_0}, 8'd0);

    // Steering to port 2 with that FIFO full, then to the invalid address.
    detect_add = 1'b1; data_in = 2'd2;
    next_cycle();
    detect_add = 1'b0; write_enb_reg = 1'b1; full = 3'b100;
    for (int c = 0; c < 3; c++) begin
      #3;
      check("pin_we_port2", {5'd0, write_enb}, 8'b100);
      check("pin_full_port2", {7'd0, fifo_full}, 8'd1);
      next_cycle();
    end
    detect_add = 1'b1; data_in = 2'd3; write_enb_reg = 1'b0;
    next_cycle();
    detect_add = 1'b0; write_enb_reg = 1'b1; full = 3'b111;
    #3;
    check("pin_we_none", {5'd0, write_enb}, 8'd0);
    check("pin_full_none", {7'd0, fifo_full}, 8'd0);
    next_cycle();

    // Header and write together: the write still uses the previous address.
    idle();
    detect_add = 1'b1; data_in = 2'd0;
    next_cycle();
    detect_add = 1'b1; data_in = 2'd1; write_enb_reg = 1'b1;
    #3;
    check("pin_hdr_old", {5'd0, write_enb}, 8'b001);
    next_cycle();
    detect_add = 1'b0;
    #3;
    check("pin_hdr_new", {5'd0, write_enb}, 8'b010);
    next_cycle();

    // Port 1 held stalled: pulses after stalled edges 30 and 60 only.
    idle();
    empty = 3'b101;
    for (int c = 1; c <= 62; c++) begin
      next_cycle();
      #3;
      check("pin_timeout_p1", {7'd0, soft_reset_1}, {7'd0, (c % 30) == 0});
    end

    // A single read on port 0 after 29 stalls restarts the full timeout.
    idle();
    do_reset();
    empty = 3'b110;
    repeat (29) next_cycle();
    read_enb = 3'b001;
    next_cycle();
    read_enb = 3'b000;
    for (int c = 1; c <= 30; c++) begin
      next_cycle();
      #3;
      check("pin_restart_p0", {7'd0, soft_reset_0}, {7'd0, c == 30});
    end

    // Reset mid-count on port 2, then ports 0 and 1 time out together.
    idle();
    empty = 3'b011;
    repeat (20) next_cycle();
    do_reset();
    repeat (29) next_cycle();
    #3;
    check("pin_rst_mid_p2", {7'd0, soft_reset_2}, 8'd0);
    idle();
    next_cycle();
    empty = 3'b100;
    repeat (30) next_cycle();
    #3;
    check("pin_simul_p01", {6'd0, soft_reset_1, soft_reset_0}, 8'b11);

    // Randomized segments with per-port read and empty densities.
    for (int seg = 0; seg < 40; seg++) begin
      int rd_pct[3];
      int em_pct[3];
      for (int i = 0; i < 3; i++) begin
        rd_pct[i] = $urandom_range(0, 3) == 0 ? 0 : $urandom_range(1, 40);
        em_pct[i] = $urandom_range(0, 2) == 0 ? 0 : $urandom_range(0, 50);
      end
      for (int c = 0; c < 80; c++) begin
        next_cycle();
        reset         = ($urandom_range(0, 199) == 0);
        detect_add    = ($urandom_range(0, 7) == 0);
        data_in       = 2'($urandom_range(0, 3));
        write_enb_reg = 1'($urandom_range(0, 1));
        full          = 3'($urandom_range(0, 7));
        for (int i = 0; i < 3; i++) begin
          read_enb[i] = ($urandom_range(0, 99) < rd_pct[i]);
          empty[i]    = ($urandom_range(0, 99) < em_pct[i]);
        end
      end
    end

    idle();
    next_cycle(); next_cycle();
    #4;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    miscompares++;
    $display("FAIL time_limit: simulation did not complete, got timeout expected finish");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/router_port_sync.md
Name: router_port_sync

Overview:
Destination-side controller for the 1x3 router. It latches the packet's 2-bit destination address and steers FIFO write enables to one of three output FIFOs. It also generates per-port vld_out toward the destination interfaces. A per-port watchdog issues soft_reset to any FIFO whose destination has not read for TIMEOUT consecutive cycles. It sits between the router FSM/register stage and the three output FIFOs.

Parameters:
TIMEOUT, 30, number of consecutive stalled cycles (vld_out high, read_en low) before soft_reset fires; legal range 2..255.
CNT_W, 5, width of each watchdog counter; must satisfy 2**CNT_W >= TIMEOUT.

Ports:
clock  input  1  system clock, all state updates on its rising edge
reset  input  1  synchronous, active-high reset
detect_add  input  1  header byte present; latch data_in as destination address
data_in  input  2  destination address from header byte bits [1:0]
write_enb_reg  input  1  FSM request to write the current byte to the addressed FIFO
empty_0, empty_1, empty_2  input  1 each  FIFO empty flags
full_0, full_1, full_2  input  1 each  FIFO full flags
read_enb_0, read_enb_1, read_enb_2  input  1 each  destination read enables, same signal the destination drives as read_en
write_enb  output  3  one-hot FIFO write enable, bit i drives FIFO i
fifo_full  output  1  full flag of the currently addressed FIFO
vld_out_0, vld_out_1, vld_out_2  output  1 each  data available at port i
soft_reset_0, soft_reset_1, soft_reset_2  output  1 each  one-cycle pulse that flushes FIFO i

Behaviour:
- Reset (reset=1 at a clock edge) forces the following state:
  - addr_q = 2'b11, the invalid/no-port value.
  - All watchdog counters = 0.
  - All soft_reset_i = 0.
  - Consequently write_enb = 3'b000 and fifo_full = 0 while reset is held.
- Address latch:
  - When detect_add=1, addr_q <= data_in on the next edge.
  - Otherwise addr_q holds its value.
- write_enb is combinational from registered addr_q:
  - If write_enb_reg=1 and addr_q is 0, 1 or 2, then write_enb = 1<<addr_q.
  - If addr_q = 3 or write_enb_reg = 0, then write_enb = 3'b000.
- fifo_full is combinational: it equals full_{addr_q}, and is 0 when addr_q = 3.
- Header and write in the same cycle (detect_add=1 and write_enb_reg=1): the write uses the OLD addr_q. The new address takes effect from the next cycle.
- vld_out_i = ~empty_i, combinational, zero latency.
- Watchdog for each port i, evaluated independently, registered:
  - stall_i = vld_out_i & ~read_enb_i.
  - If stall_i=0: cnt_i <= 0 and soft_reset_i <= 0.
  - If stall_i=1 and cnt_i == TIMEOUT-1: soft_reset_i <= 1 and cnt_i <= 0.
  - If stall_i=1 otherwise: cnt_i <= cnt_i+1 and soft_reset_i <= 0.
  - Result: soft_reset_i rises exactly TIMEOUT edges after the first stalled edge and lasts one cycle.
  - If the stall persists (for example the FIFO does not flush), the pulse repeats every TIMEOUT cycles.
- A read in any cycle (read_enb_i=1) clears cnt_i, so a single read restarts the full timeout.
- FIFO going empty clears cnt_i on the next edge.
- Reset asserted mid-count clears the counter. No soft_reset pulse is produced in the reset cycle or the cycle after.
- Ports never interact: simultaneous timeouts on several ports pulse their soft_reset outputs in the same cycle.
- Counter arithmetic is unsigned CNT_W bits. It never wraps, because it is cleared at TIMEOUT-1.

Test Plan:
- Reset, then drive idle inputs -> write_enb=000, fifo_full=0, soft_reset_0..2=0, vld_out_i = ~empty_i.
- Address steering:
  - detect_add=1 with data_in=2, then write_enb_reg=1 for 3 cycles with full_2=1 -> write_enb=100 in all 3 cycles, fifo_full=1.
  - Repeat with data_in=3 -> write_enb=000, fifo_full=0.
- Header-cycle write: addr_q=0, then detect_add=1 with data_in=1 and write_enb_reg=1 in the same cycle -> write_enb=001 in that cycle, 010 in the next.
- Timeout: empty_1=0 and read_enb_1=0 held from cycle 0 -> soft_reset_1=1 only after edge 30, low before and for the cycle after. Repeats after edge 60 if empty_1 stays 0.
- Read resets watchdog: stall port 0 for 29 cycles, read_enb_0=1 for 1 cycle, stall again -> soft_reset_0 fires 30 edges after the restart, not at edge 30.
- Reset mid-count: stall port 2 for 20 cycles, then reset=1 for 1 cycle, then stall again -> no pulse until 30 stalled edges after reset is released. Ports 0 and 1 stalled together hit timeout -> both soft_reset pulses occur in the same cycle.
